hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage IF/ID/EX/MEM/WB integer pipeline.
- Keeps a shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Detects load-use hazards and stalls IF/ID. Flushes younger stages on an EX-stage redirect (taken branch/jump).
- Produces registered forwarding selects for both ALU operands of the instruction in EX.

Parameters:
- REG_ADDR_W, 5, register address width; register 0 is hardwired zero.
- CNT_W, 32, width of performance counters (used only with HAZARD_PERF_CNT_EN).

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs1_addr  input  REG_ADDR_W  ID source 1
- id_rs2_addr  input  REG_ADDR_W  ID source 2
- id_rs1_used  input  1  ID instruction reads rs1
- id_rs2_used  input  1  ID instruction reads rs2
- id_rd_addr  input  REG_ADDR_W  ID destination
- id_reg_w_en  input  1  ID instruction writes rd
- id_is_load  input  1  ID instruction is a load
- ex_redirect  input  1  EX instruction redirects fetch this cycle
- stall  output  1  hold PC and IF/ID register (combinational)
- flush_if_id  output  1  load NOP into IF/ID (combinational)
- bubble_id_ex  output  1  load NOP into ID/EX (combinational)
- fwd_a_sel  output  2  EX operand 1 source: 0 regfile, 1 EX/MEM alu_out, 2 MEM/WB write data (registered)
- fwd_b_sel  output  2  EX operand 2 source, same encoding (registered)
- stall_cnt  output  CNT_W  stall cycles (HAZARD_PERF_CNT_EN only)
- flush_cnt  output  CNT_W  redirect events (HAZARD_PERF_CNT_EN only)

Behaviour:
- Shadow state: ex_{rd,w,load}, mem_{rd,w,load}, wb_{rd,w}.
- A stage "writes r" iff its w is 1, rd==r and r!=0.
- Load-use hazard:
  - hz = id_valid & ex_w & ex_load & ex_rd!=0 & ((id_rs1_used & id_rs1_addr==ex_rd) | (id_rs2_used & id_rs2_addr==ex_rd)).
  - stall = hz & !ex_redirect.
- Redirect:
  - flush_if_id = ex_redirect.
  - bubble_id_ex = ex_redirect | stall.
  - Redirect has priority over stall; stall is 0 during a redirect.
- Shadow update each edge:
  - wb <= mem; mem <= ex.
  - ex <= id fields if id_valid & !bubble_id_ex; otherwise ex_w <= 0 and ex_load <= 0.
- Forwarding, computed for the ID instruction and registered into fwd_*_sel on the same edge it enters EX:
  - Operand matches ex stage (non-load): sel 1.
  - Else operand matches mem stage: sel 2 (covers ALU results and load data one stage later).
  - Else sel 0.
  - Priority: ex over mem (youngest wins).
  - An unused operand gives sel 0.
  - When bubble_id_ex=1, both sels <= 0.
- No WB-stage case: the regfile is write-through on same-cycle read/write.
- Stall latency: exactly 1 cycle per load-use. The following cycle, the load is in mem and sel=2.
- Back-to-back redirects: each cycle flushes independently.
- Reset, including mid-stall or mid-redirect:
  - All shadow w/load flags <= 0.
  - fwd_a_sel and fwd_b_sel <= 0.
  - Counters <= 0.
  - Combinational stall, flush_if_id and bubble_id_ex then evaluate to 0 unless ex_redirect is asserted.
- No state machine beyond the shadow pipeline; the control is fully deterministic per cycle.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with ex_redirect=1.
  - Both wrap modulo 2^CNT_W and are cleared by rst.
- Undefined: the counter ports and logic are absent.

Test Plan:
- ALU chain: addi x5; add x6,x5,x5 next cycle -> stall=0; when the add is in EX, fwd_a_sel=1 and fwd_b_sel=1.
- Gap of one: addi x5; nop; sub x7,x5,x1 -> sub in EX with fwd_a_sel=2, fwd_b_sel=0.
- Load-use: lw x8; add x9,x8,x2 -> stall=1 and bubble_id_ex=1 for exactly 1 cycle; then add in EX with fwd_a_sel=2; stall_cnt=1.
- x0 destination: addi x0 followed by a reader of x0 -> no forward (sel 0), no stall, even for lw x0.
- Redirect vs stall: ex_redirect=1 in the same cycle as a load-use hz -> stall=0, flush_if_id=1, bubble_id_ex=1; next cycle sels=0; flush_cnt=1.
- Reset mid-stall: assert rst while stall=1 -> next cycle stall=0, sels=0, counters=0; a reader of the old load's rd is not stalled.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Hazard and forwarding controller for the 5-stage IF/ID/EX/MEM/WB integer
// pipeline. A small shadow pipeline tracks destination-register information
// for the instructions in EX and MEM. From it the block:
//   - detects load-use hazards and stalls IF/ID for one cycle,
//   - flushes the younger stages when EX redirects fetch,
//   - produces registered forwarding selects for both ALU operands of the
//     instruction that is about to enter EX.
//
// Optional feature (compile-time macro HAZARD_PERF_CNT_EN):
//   When defined, the CNT_W parameter and the stall_cnt / flush_cnt
//   performance counter ports exist. When undefined they are absent.
//
// Parameters:
//   REG_ADDR_W  register address width; register 0 is hardwired zero
//   CNT_W       performance counter width (HAZARD_PERF_CNT_EN only)
//
// Ports:
//   clk            pipeline clock, all state on rising edge
//   rst            synchronous active-high reset
//   id_valid       ID stage holds a real instruction
//   id_rs1_addr    ID source register 1
//   id_rs2_addr    ID source register 2
//   id_rs1_used    ID instruction reads rs1
//   id_rs2_used    ID instruction reads rs2
//   id_rd_addr     ID destination register
//   id_reg_w_en    ID instruction writes rd
//   id_is_load     ID instruction is a load
//   ex_redirect    EX instruction redirects fetch this cycle
//   stall          hold PC and IF/ID register (combinational)
//   flush_if_id    load NOP into IF/ID (combinational)
//   bubble_id_ex   load NOP into ID/EX (combinational)
//   fwd_a_sel      EX operand 1 source: 0 regfile, 1 EX/MEM alu_out,
//                  2 MEM/WB write data (registered)
//   fwd_b_sel      EX operand 2 source, same encoding (registered)
//   stall_cnt      stall cycle count (HAZARD_PERF_CNT_EN only)
//   flush_cnt      redirect event count (HAZARD_PERF_CNT_EN only)
// ============================================================================
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_w_en,
    input  logic                  id_is_load,
    input  logic                  ex_redirect,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  bubble_id_ex,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    // Forwarding select encoding.
    localparam logic [1:0] SEL_REGFILE = 2'd0;
    localparam logic [1:0] SEL_EX_MEM  = 2'd1;
    localparam logic [1:0] SEL_MEM_WB  = 2'd2;

    // ------------------------------------------------------------------------
    // Shadow pipeline. Only the EX and MEM entries can influence any output:
    // the register file is write-through, so an instruction in WB never needs
    // a forward, and a load already in MEM is forwarded exactly like an ALU
    // result. The WB entry and the MEM load flag would therefore be dead
    // registers and are not kept.
    // ------------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_w;
    logic                  ex_load;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_w;

    // Combinational hazard and next-select signals.
    logic                  ex_hits_rs1;
    logic                  ex_hits_rs2;
    logic                  mem_hits_rs1;
    logic                  mem_hits_rs2;
    logic                  load_use_hz;
    logic [1:0]            fwd_a_next;
    logic [1:0]            fwd_b_next;

    // ------------------------------------------------------------------------
    // Register-match detection. A stage "writes r" only when it really writes
    // and r is not x0; reads of x0 therefore never match and never stall or
    // forward. Unused operands are masked out here so that a stale address
    // field in the instruction cannot create a false hazard.
    // ------------------------------------------------------------------------
    always_comb begin
        ex_hits_rs1  = 1'b0;
        ex_hits_rs2  = 1'b0;
        mem_hits_rs1 = 1'b0;
        mem_hits_rs2 = 1'b0;

        if (id_valid && id_rs1_used && (id_rs1_addr != '0)) begin
            ex_hits_rs1  = ex_w  && (ex_rd  == id_rs1_addr);
            mem_hits_rs1 = mem_w && (mem_rd == id_rs1_addr);
        end

        if (id_valid && id_rs2_used && (id_rs2_addr != '0)) begin
            ex_hits_rs2  = ex_w  && (ex_rd  == id_rs2_addr);
            mem_hits_rs2 = mem_w && (mem_rd == id_rs2_addr);
        end
    end

    // ------------------------------------------------------------------------
    // Load-use hazard and pipeline control. A load in EX only has its data at
    // the end of MEM, so a dependent instruction in ID must wait one cycle.
    // A redirect discards the ID instruction anyway, so it overrides the
    // stall: stalling on a squashed instruction would only waste a cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        load_use_hz  = ex_load && (ex_hits_rs1 || ex_hits_rs2);
        stall        = load_use_hz && !ex_redirect;
        flush_if_id  = ex_redirect;
        bubble_id_ex = ex_redirect || stall;
    end

    // ------------------------------------------------------------------------
    // Next forwarding selects for the ID instruction. On the coming edge the
    // current EX entry moves to MEM (its result sits in EX/MEM) and the
    // current MEM entry moves to WB (its result sits in MEM/WB). The younger
    // producer wins. A load in EX is never a forwarding source: that case is
    // always a stall or a redirect, both of which bubble ID/EX.
    // ------------------------------------------------------------------------
    always_comb begin
        fwd_a_next = SEL_REGFILE;
        fwd_b_next = SEL_REGFILE;

        if (!bubble_id_ex) begin
            if (ex_hits_rs1 && !ex_load) begin
                fwd_a_next = SEL_EX_MEM;
            end else if (mem_hits_rs1) begin
                fwd_a_next = SEL_MEM_WB;
            end

            if (ex_hits_rs2 && !ex_load) begin
                fwd_b_next = SEL_EX_MEM;
            end else if (mem_hits_rs2) begin
                fwd_b_next = SEL_MEM_WB;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shadow pipeline advance and registered forwarding selects. The EX entry
    // takes the ID fields only when a real instruction actually enters EX;
    // a bubble clears the write and load flags. The destination address is
    // still captured on a bubble since it is meaningless without ex_w.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rd     <= '0;
            ex_w      <= 1'b0;
            ex_load   <= 1'b0;
            mem_rd    <= '0;
            mem_w     <= 1'b0;
            fwd_a_sel <= SEL_REGFILE;
            fwd_b_sel <= SEL_REGFILE;
        end else begin
            mem_rd <= ex_rd;
            mem_w  <= ex_w;

            ex_rd <= id_rd_addr;
            if (id_valid && !bubble_id_ex) begin
                ex_w    <= id_reg_w_en;
                ex_load <= id_is_load;
            end else begin
                ex_w    <= 1'b0;
                ex_load <= 1'b0;
            end

            fwd_a_sel <= fwd_a_next;
            fwd_b_sel <= fwd_b_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters: one count per stalled cycle and one per redirect
    // cycle. They wrap naturally at 2^CNT_W.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ex_redirect) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for hazard_ctrl. The stimulus process drives one ID-stage
// instruction per cycle, asks a reference model what the controller must
// present during that cycle and queues the answer. A separate monitor pops
// each entry and compares it with the DUT outputs.
//
// The reference model keeps the in-flight instructions in a two-entry array
// (EX, MEM) and answers "who is the youngest in-flight producer of register
// r?" to derive hazards and forwarding.
// ============================================================================
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd_addr;
    logic       id_reg_w_en;
    logic       id_is_load;
    logic       ex_redirect;
    logic       stall;
    logic       flush_if_id;
    logic       bubble_id_ex;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd_addr   (id_rd_addr),
        .id_reg_w_en  (id_reg_w_en),
        .id_is_load   (id_is_load),
        .ex_redirect  (ex_redirect),
        .stall        (stall),
        .flush_if_id  (flush_if_id),
        .bubble_id_ex (bubble_id_ex),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-flight instruction as seen by the model.
    typedef struct {
        logic       w;
        logic       load;
        logic [4:0] rd;
    } slot_t;

    // Expected DUT presentation for one cycle.
    typedef struct {
        logic        stall;
        logic        flush;
        logic        bubble;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    slot_t       pipe [2];
    logic [1:0]  m_fa;
    logic [1:0]  m_fb;
    logic [31:0] m_sc;
    logic [31:0] m_fc;
    exp_t        sb_q [$];
    int          n_checks;
    int          n_fail;
    int          cycle;

    // Index of the youngest in-flight stage writing r (0 = EX, 1 = MEM),
    // or -1 when nothing in flight produces r. x0 is never produced.
    function automatic int producer(input logic [4:0] r);
        if (r == 5'd0) return -1;
        for (int s = 0; s < 2; s++) begin
            if (pipe[s].w && pipe[s].rd == r) return s;
        end
        return -1;
    endfunction

    // Where an operand will come from once the instruction reaches EX.
    function automatic logic [1:0] sel_of(input logic v, input logic u,
                                          input logic [4:0] a);
        int p;
        if (!v || !u) return 2'd0;
        p = producer(a);
        if (p == 0) return pipe[0].load ? 2'd0 : 2'd1;
        if (p == 1) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic needs_load_data(input logic v, input logic u,
                                             input logic [4:0] a);
        return v && u && producer(a) == 0 && pipe[0].load;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            pipe[s].w    = 1'b0;
            pipe[s].load = 1'b0;
            pipe[s].rd   = 5'd0;
        end
        m_fa = 2'd0;
        m_fb = 2'd0;
        m_sc = 32'd0;
        m_fc = 32'd0;
    endtask

    // Drive one cycle of ID-stage inputs, queue the expected presentation
    // and advance the model past the following rising edge.
    task automatic applyStimulus(input logic v, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1,
                                 input logic u2, input logic [4:0] rd,
                                 input logic w, input logic ld,
                                 input logic redir, input logic r);
        exp_t e;
        logic hz;
        @(negedge clk);
        cycle++;
        id_valid    = v;
        id_rs1_addr = rs1;
        id_rs2_addr = rs2;
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd_addr  = rd;
        id_reg_w_en = w;
        id_is_load  = ld;
        ex_redirect = redir;
        rst         = r;

        hz       = needs_load_data(v, u1, rs1) || needs_load_data(v, u2, rs2);
        e.stall  = hz && !redir;
        e.flush  = redir;
        e.bubble = redir || e.stall;
        e.fa     = m_fa;
        e.fb     = m_fb;
        e.sc     = m_sc;
        e.fc     = m_fc;
        sb_q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            m_sc = m_sc + (e.stall ? 32'd1 : 32'd0);
            m_fc = m_fc + (redir ? 32'd1 : 32'd0);
            m_fa = e.bubble ? 2'd0 : sel_of(v, u1, rs1);
            m_fb = e.bubble ? 2'd0 : sel_of(v, u2, rs2);
            pipe[1] = pipe[0];
            pipe[0].rd   = rd;
            pipe[0].w    = v && !e.bubble && w;
            pipe[0].load = v && !e.bubble && ld;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL cycle %0d %s: got %0h expected %0h",
                     cycle, name, got, exp);
        end
    endtask

    // Convenience wrappers for readable directed sequences.
    task automatic nop(input logic redir = 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, redir, 1'b0);
    endtask

    // Monitor: every cycle, once the inputs have settled, compare the DUT
    // with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("stall",        {31'd0, stall},        {31'd0, e.stall});
                checkOutput("flush_if_id",  {31'd0, flush_if_id},  {31'd0, e.flush});
                checkOutput("bubble_id_ex", {31'd0, bubble_id_ex}, {31'd0, e.bubble});
                checkOutput("fwd_a_sel",    {30'd0, fwd_a_sel},    {30'd0, e.fa});
                checkOutput("fwd_b_sel",    {30'd0, fwd_b_sel},    {30'd0, e.fb});
`ifdef HAZARD_PERF_CNT_EN
                checkOutput("stall_cnt",    stall_cnt,             e.sc);
                checkOutput("flush_cnt",    flush_cnt,             e.fc);
`endif
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cycle    = 0;
        rst         = 1'b1;
        id_valid    = 1'b0;
        id_rs1_addr = 5'd0;
        id_rs2_addr = 5'd0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        id_rd_addr  = 5'd0;
        id_reg_w_en = 1'b0;
        id_is_load  = 1'b0;
        ex_redirect = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        $display("[TB] reset state");
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        nop();

        $display("[TB] ALU chain: addi x5; add x6,x5,x5");
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        nop();
        nop();

        $display("[TB] gap of one: addi x5; nop; sub x7,x5,x1");
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        nop();
        applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        nop();
        nop();

        $display("[TB] load-use: lw x8; add x9,x8,x2");
        applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        nop();
        nop();

        $display("[TB] x0 destination");
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        nop();
        nop();

        $display("[TB] redirect vs stall");
        applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        nop();
        nop(1'b1);
        nop(1'b1);
        nop();

        $display("[TB] reset mid-stall");
        applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        nop();
        nop();

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom),
                          5'($urandom_range(0, 3)),
                          ($urandom_range(0, 4) != 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 59) == 0));
        end
        nop();
        nop();

        @(negedge clk);
        #5;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
